// File: rtl/dcache_write_buffer_pkg.sv
// dcache_write_buffer_pkg: shared sizing, AXI strobe constant and drain FSM encodings
package dcache_write_buffer_pkg;
    localparam int WB_DEPTH = 4;
    localparam int WB_LINE_WORDS = 8;
    localparam int WB_ADDR_W = 32;
    localparam logic [3:0] WB_AXI_SEL = 4'hF;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;
endpackage

// File: rtl/dcache_write_buffer_wb_query_match.sv
// wb_query_match: newest-entry line match for refill forwarding (present only with DCACHE_WB_FORWARD_EN)
//   head_i/count_i : FIFO occupancy, entries head..head+count-1 are valid (oldest first)
//   tag_i/line_i   : per-entry line tag and data
//   query_tag_i    : refill address with the line-offset bits stripped
//   hit_o/line_o   : match flag and newest matching line, zero on miss
module wb_query_match
    import dcache_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int LINE_WORDS = WB_LINE_WORDS,
    parameter int TAG_W = 27,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [PTR_W-1:0]                       head_i,
    input  logic [PTR_W:0]                         count_i,
    input  logic [DEPTH-1:0][TAG_W-1:0]            tag_i,
    input  logic [DEPTH-1:0][32*LINE_WORDS-1:0]    line_i,
    input  logic [TAG_W-1:0]                       query_tag_i,
    output logic                                   hit_o,
    output logic [32*LINE_WORDS-1:0]               line_o
);
`ifdef DCACHE_WB_FORWARD_EN
    logic [PTR_W-1:0] idx;
    // Walk from oldest to newest so a later (newer) match overrides an earlier one.
    always_comb begin
        hit_o = 1'b0;
        line_o = '0;
        idx = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if ((PTR_W+1)'(k) < count_i && tag_i[idx] == query_tag_i) begin
                hit_o = 1'b1;
                line_o = line_i[idx];
            end
        end
    end
`else
    logic unused_query;
    assign unused_query = ^{head_i, count_i, tag_i, line_i, query_tag_i};
    assign hit_o = 1'b0;
    assign line_o = '0;
`endif
endmodule

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: DCache victim line FIFO draining each line as one AXI INCR burst
//   push_*  : whole-line enqueue from the eviction path, refused while full_o
//   query_* : refill address check against buffered lines (macro DCACHE_WB_FORWARD_EN)
//   axi_*   : AW / W / B write channel
//   empty_o : nothing buffered and drain FSM idle
module dcache_write_buffer
    import dcache_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int LINE_WORDS = WB_LINE_WORDS,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         push_i,
    input  logic [ADDR_W-1:0]            push_addr_i,
    input  logic [32*LINE_WORDS-1:0]     push_line_i,
    output logic                         full_o,
    output logic                         empty_o,
    input  logic [ADDR_W-1:0]            query_addr_i,
    output logic                         query_hit_o,
    output logic [32*LINE_WORDS-1:0]     query_line_o,
    output logic                         axi_wen_o,
    output logic [ADDR_W-1:0]            axi_waddr_o,
    output logic [3:0]                   axi_wlen_o,
    output logic [3:0]                   axi_sel_o,
    input  logic                         axi_awready_i,
    output logic [31:0]                  axi_wdata_o,
    output logic                         axi_wvalid_o,
    output logic                         axi_wlast_o,
    input  logic                         axi_wready_i,
    input  logic                         axi_bvalid_i
);
    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int BEAT_W = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
    // Only the line tag is stored; the offset bits are zero by construction.
    logic [DEPTH-1:0][TAG_W-1:0] tag_q;
    logic [DEPTH-1:0][32*LINE_WORDS-1:0] line_q;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0] count_q, count_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [1:0] state_q, state_d;
    logic push_ok, pop, last_beat, unused_offsets;
    assign unused_offsets = ^{push_addr_i[OFF_W-1:0], query_addr_i[OFF_W-1:0]};
    // full_o comes from registered count only, so a same-cycle pop never admits a push.
    assign full_o = count_q == (PTR_W+1)'(DEPTH);
    assign empty_o = count_q == '0 && state_q == S_IDLE;
    assign push_ok = push_i && !full_o;
    assign pop = state_q == S_RESP && axi_bvalid_i;
    assign last_beat = beat_q == BEAT_W'(LINE_WORDS - 1);
    assign axi_wen_o = state_q == S_ADDR;
    assign axi_waddr_o = axi_wen_o ? {tag_q[head_q], OFF_W'(0)} : '0;
    assign axi_wlen_o = 4'(LINE_WORDS - 1);
    assign axi_sel_o = WB_AXI_SEL;
    assign axi_wvalid_o = state_q == S_DATA;
    assign axi_wdata_o = axi_wvalid_o ? line_q[head_q][beat_q*32 +: 32] : '0;
    assign axi_wlast_o = axi_wvalid_o && last_beat;
    always_comb begin
        state_d = state_q;
        beat_d = beat_q;
        case (state_q)
            S_IDLE: state_d = count_q != '0 ? S_ADDR : S_IDLE;
            S_ADDR: begin
                state_d = axi_awready_i ? S_DATA : S_ADDR;
                beat_d = axi_awready_i ? '0 : beat_q;
            end
            S_DATA: begin
                state_d = axi_wready_i && last_beat ? S_RESP : S_DATA;
                beat_d = axi_wready_i ? beat_q + 1'b1 : beat_q;
            end
            default: state_d = pop ? S_IDLE : S_RESP;
        endcase
        head_d = head_q + PTR_W'(pop);
        tail_d = tail_q + PTR_W'(push_ok);
        count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            beat_q <= '0;
            state_q <= S_IDLE;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            beat_q <= beat_d;
            state_q <= state_d;
        end
    end
    // Storage needs no reset: validity is defined by head/count alone.
    always_ff @(posedge aclk) begin
        if (push_ok) begin
            tag_q[tail_q] <= push_addr_i[ADDR_W-1:OFF_W];
            line_q[tail_q] <= push_line_i;
        end
    end
    wb_query_match #(
        .DEPTH(DEPTH),
        .LINE_WORDS(LINE_WORDS),
        .TAG_W(TAG_W),
        .PTR_W(PTR_W)
    ) u_query (
        .head_i(head_q),
        .count_i(count_q),
        .tag_i(tag_q),
        .line_i(line_q),
        .query_tag_i(query_addr_i[ADDR_W-1:OFF_W]),
        .hit_o(query_hit_o),
        .line_o(query_line_o)
    );
endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: scoreboard bench for the victim write buffer
module tb_dcache_write_buffer;
`ifdef DCACHE_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    logic aclk, aresetn, push_i, full_o, empty_o, query_hit_o;
    logic [31:0] push_addr_i, query_addr_i, axi_waddr_o, axi_wdata_o;
    logic [255:0] push_line_i, query_line_o;
    logic axi_wen_o, axi_awready_i, axi_wvalid_o, axi_wlast_o, axi_wready_i, axi_bvalid_i;
    logic [3:0] axi_wlen_o, axi_sel_o;
    int checks, failures;
    logic [31:0] exp_addr_q[$];
    logic [32:0] exp_beat_q[$];
    bit b_pend, hold_chk;
    logic [31:0] hold_data;
    logic [255:0] lx, ly;

    dcache_write_buffer dut (
        .aclk(aclk), .aresetn(aresetn),
        .push_i(push_i), .push_addr_i(push_addr_i), .push_line_i(push_line_i),
        .full_o(full_o), .empty_o(empty_o),
        .query_addr_i(query_addr_i), .query_hit_o(query_hit_o), .query_line_o(query_line_o),
        .axi_wen_o(axi_wen_o), .axi_waddr_o(axi_waddr_o), .axi_wlen_o(axi_wlen_o),
        .axi_sel_o(axi_sel_o), .axi_awready_i(axi_awready_i),
        .axi_wdata_o(axi_wdata_o), .axi_wvalid_o(axi_wvalid_o), .axi_wlast_o(axi_wlast_o),
        .axi_wready_i(axi_wready_i), .axi_bvalid_i(axi_bvalid_i)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string n, input logic [259:0] a, input logic [259:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [255:0] mk(input logic [31:0] b);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = b + 32'(i);
        return r;
    endfunction

    task automatic exp_push(input logic [31:0] a, input logic [255:0] l);
        exp_addr_q.push_back(a & ~32'h1F);
        for (int i = 0; i < 8; i++) exp_beat_q.push_back({i == 7, l[i*32 +: 32]});
    endtask

    task automatic do_push(input logic [31:0] a, input logic [255:0] l, input bit acc);
        push_i = 1'b1;
        push_addr_i = a;
        push_line_i = l;
        #1;
        chk("push_gate_full", {259'b0, full_o}, {259'b0, !acc});
        if (acc) exp_push(a, l);
        @(posedge aclk);
        #1;
        push_i = 1'b0;
    endtask

    task automatic wait_empty(input string n);
        for (int i = 0; i < 300; i++) begin
            @(posedge aclk);
            #1;
            if (empty_o) break;
        end
        chk(n, {259'b0, empty_o}, {259'b0, 1'b1});
    endtask

    task automatic chk_reset_outputs(input string n);
        chk(n, {axi_wen_o, axi_waddr_o, axi_wlen_o, axi_sel_o, axi_wdata_o, axi_wvalid_o, axi_wlast_o,
                full_o, empty_o, query_hit_o},
            {1'b0, 32'h0, 4'd7, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    endtask

    // B-channel responder: one cycle of bvalid after each last-beat handshake.
    always @(posedge aclk) begin
        #1;
        axi_bvalid_i = b_pend;
        b_pend = 1'b0;
    end

    // Monitor: compares every AW and W handshake against the scoreboard queues.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (hold_chk) chk("beat_hold", {227'b0, axi_wvalid_o, axi_wdata_o}, {227'b0, 1'b1, hold_data});
            hold_chk = axi_wvalid_o && !axi_wready_i;
            hold_data = axi_wdata_o;
            if (axi_wen_o && axi_awready_i) begin
                if (exp_addr_q.size() == 0) chk("aw_unexpected", {228'b0, axi_waddr_o}, 260'h0 - 1);
                else begin
                    chk("aw_addr", {228'b0, axi_waddr_o}, {228'b0, exp_addr_q.pop_front()});
                    chk("aw_len", {256'b0, axi_wlen_o}, {256'b0, 4'd7});
                end
            end
            if (axi_wvalid_o && axi_wready_i) begin
                if (exp_beat_q.size() == 0) chk("w_unexpected", {227'b0, axi_wlast_o, axi_wdata_o}, 260'h0 - 1);
                else chk("w_beat", {227'b0, axi_wlast_o, axi_wdata_o}, {227'b0, exp_beat_q.pop_front()});
                if (axi_wlast_o) b_pend = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        checks = 0;
        failures = 0;
        aresetn = 1'b0;
        push_i = 1'b0;
        push_addr_i = '0;
        push_line_i = '0;
        query_addr_i = '0;
        axi_awready_i = 1'b1;
        axi_wready_i = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk_reset_outputs("reset_state");
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        // Single line burst.
        do_push(32'h1FC0_0020, mk(32'h11), 1'b1);
        wait_empty("single_drained");
        // Fill with AW stalled, refused 5th push, ordered drain.
        axi_awready_i = 1'b0;
        do_push(32'h0000_0104, mk(32'h100), 1'b1);
        do_push(32'h0000_0200, mk(32'h200), 1'b1);
        do_push(32'h0000_0300, mk(32'h300), 1'b1);
        do_push(32'h0000_0400, mk(32'h400), 1'b1);
        do_push(32'h0000_0500, mk(32'h500), 1'b0);
        chk("full_held", {259'b0, full_o}, {259'b0, 1'b1});
        chk("aw_stalled", {227'b0, axi_wen_o, axi_waddr_o}, {227'b0, 1'b1, 32'h0000_0100});
        axi_awready_i = 1'b1;
        wait_empty("four_drained");
        // W backpressure toggling.
        do_push(32'h0000_2000, mk(32'hA0), 1'b1);
        for (int i = 0; i < 200; i++) begin
            @(posedge aclk);
            #1;
            axi_wready_i = !axi_wready_i;
            if (empty_o) break;
        end
        chk("toggle_drained", {259'b0, empty_o}, {259'b0, 1'b1});
        axi_wready_i = 1'b1;
        // Forwarding query, newest match wins.
        lx = mk(32'hC0);
        ly = mk(32'hD0);
        axi_awready_i = 1'b0;
        query_addr_i = 32'h0000_1000;
        push_i = 1'b1;
        push_addr_i = 32'h0000_1000;
        push_line_i = lx;
        #1;
        chk("query_push_same_cycle", {3'b0, query_hit_o, query_line_o}, 260'h0);
        exp_push(32'h0000_1000, lx);
        @(posedge aclk);
        #1;
        push_i = 1'b0;
        chk("query_first", {3'b0, query_hit_o, query_line_o}, {3'b0, FWD, FWD ? lx : 256'h0});
        do_push(32'h0000_1000, ly, 1'b1);
        query_addr_i = 32'h0000_1014;
        #1;
        chk("query_newest", {3'b0, query_hit_o, query_line_o}, {3'b0, FWD, FWD ? ly : 256'h0});
        query_addr_i = 32'h0000_1020;
        #1;
        chk("query_next_line_miss", {3'b0, query_hit_o, query_line_o}, 260'h0);
        query_addr_i = 32'h0000_1014;
        axi_awready_i = 1'b1;
        wait_empty("query_lines_drained");
        chk("query_after_drain", {3'b0, query_hit_o, query_line_o}, 260'h0);
        // Push held while full and a pop happens.
        axi_awready_i = 1'b0;
        do_push(32'h0000_3000, mk(32'h3000), 1'b1);
        do_push(32'h0000_3020, mk(32'h3020), 1'b1);
        do_push(32'h0000_3040, mk(32'h3040), 1'b1);
        do_push(32'h0000_3060, mk(32'h3060), 1'b1);
        push_i = 1'b1;
        push_addr_i = 32'h0000_4000;
        push_line_i = mk(32'h4000);
        axi_awready_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (axi_bvalid_i) break;
        end
        chk("pop_seen", {259'b0, axi_bvalid_i}, {259'b0, 1'b1});
        chk("push_refused_on_pop", {259'b0, full_o}, {259'b0, 1'b1});
        @(posedge aclk);
        #1;
        chk("room_after_pop", {259'b0, full_o}, {259'b0, 1'b0});
        exp_push(32'h0000_4000, mk(32'h4000));
        @(posedge aclk);
        #1;
        push_i = 1'b0;
        chk("refilled_full", {259'b0, full_o}, {259'b0, 1'b1});
        wait_empty("refill_drained");
        // Reset in the middle of a burst.
        do_push(32'h0000_5000, mk(32'h5000), 1'b1);
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (axi_wvalid_o) break;
        end
        chk("burst_started", {259'b0, axi_wvalid_o}, {259'b0, 1'b1});
        @(posedge aclk);
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        exp_addr_q.delete();
        exp_beat_q.delete();
        #1;
        chk_reset_outputs("async_reset_mid_burst");
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (10) @(posedge aclk);
        #1;
        chk("post_reset_idle", {257'b0, axi_wen_o, axi_wvalid_o, empty_o}, {257'b0, 1'b0, 1'b0, 1'b1});
        chk("scoreboard_empty", 260'(exp_addr_q.size() + exp_beat_q.size()), 260'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache_write_buffer.md
Name: dcache_write_buffer

Overview:
- Victim write buffer between the DCache eviction path and the AXI interface write port.
- Accepts whole dirty lines from the DCache in one cycle and holds them in a FIFO of DEPTH entries.
- Drains each entry as one INCR burst of LINE_WORDS 32-bit beats.
- Lets the DCache check a refill address against buffered lines, so a read never fetches stale memory.

Parameters:
- DEPTH, 4: number of line entries; power of 2, at least 2.
- LINE_WORDS, 8: 32-bit words per line; power of 2, at most 16.
- ADDR_W, 32: physical address width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- push_i  in  1  DCache presents an evicted line
- push_addr_i  in  ADDR_W  line-aligned address; low log2(LINE_WORDS)+2 bits are ignored and stored as 0
- push_line_i  in  32*LINE_WORDS  line data; word 0 in bits [31:0]
- full_o  out  1  no free entry; push is refused
- empty_o  out  1  no entries and drain FSM idle
- query_addr_i  in  ADDR_W  DCache refill address
- query_hit_o  out  1  a buffered line matches query_addr_i
- query_line_o  out  32*LINE_WORDS  data of the newest matching entry
- axi_wen_o  out  1  write-address request
- axi_waddr_o  out  ADDR_W  burst start address
- axi_wlen_o  out  4  LINE_WORDS-1
- axi_sel_o  out  4  byte strobes, constant 4'hF
- axi_awready_i  in  1  address accepted
- axi_wdata_o  out  32  current beat
- axi_wvalid_o  out  1  beat valid
- axi_wlast_o  out  1  last beat
- axi_wready_i  in  1  beat accepted
- axi_bvalid_i  in  1  burst write response

Behaviour:
- Reset (async, aresetn=0):
  - head, tail, count, beat_cnt <= 0; FSM <= IDLE.
  - All axi_* outputs 0 except axi_sel_o=4'hF and axi_wlen_o=LINE_WORDS-1.
  - full_o=0, empty_o=1, query_hit_o=0.
- Push:
  - Accepted on a rising edge with push_i=1 and full_o=0. Entry written at tail; tail and count increment.
  - full_o = (count==DEPTH) and is registered-state based. A pop in the same cycle does not make room for a push that cycle.
  - push_i while full_o=1 is ignored and state is unchanged. The DCache must stall until full_o=0.
- Pointers: head and tail wrap modulo DEPTH. count runs 0..DEPTH.
- Drain FSM, states IDLE -> ADDR -> DATA -> RESP -> IDLE:
  - IDLE: if count>0, move to ADDR the next cycle.
  - ADDR: axi_wen_o=1, axi_waddr_o=entry[head].addr. Both are held stable until axi_awready_i=1, then go to DATA with beat_cnt=0.
  - DATA:
    - axi_wvalid_o=1, axi_wdata_o=entry[head].word[beat_cnt], axi_wlast_o=(beat_cnt==LINE_WORDS-1).
    - Each cycle with axi_wready_i=1 increments beat_cnt. Data holds while axi_wready_i=0.
    - A handshake on the last beat goes to RESP.
  - RESP:
    - Wait for axi_bvalid_i=1, then pop: head+1, count-1, go to IDLE.
    - Minimum 1 idle cycle between bursts.
- Entry lifetime: the entry stays resident and queryable until it is popped in RESP.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Query:
  - Purely combinational, same cycle, over all valid entries including the one being drained.
  - Address compare ignores the line-offset bits.
  - Multiple matches (same line pushed twice): the newest entry, the one nearest tail, wins.
  - query_line_o is all-zero when query_hit_o=0.
  - A push accepted this cycle is not visible to the query until the next cycle.
- empty_o = (count==0) and FSM==IDLE.
- Reset asserted mid-burst: the buffer is discarded immediately and outputs return to reset values. Recovering the AXI interface is the system reset's job.

Optional Feature:
- Macro: DCACHE_WB_FORWARD_EN.
- Defined: query logic present as described above.
- Undefined:
  - Query logic is removed; query_hit_o=0 and query_line_o=0.
  - The DCache must instead stall any read miss until empty_o=1.
  - Port list is unchanged.

Decomposition:
- Shared package/header holds: LINE_WORDS, DEPTH, the constant axi_sel_o strobe, and the drain FSM state encodings (IDLE=2'd0, ADDR=2'd1, DATA=2'd2, RESP=2'd3).
- One natural sub-module: wb_query_match. It does the combinational newest-match priority search over the valid mask, addresses and head/tail pointers, and contains everything the macro removes.

Test Plan:
- Reset, then push addr 0x1FC0_0020 with words 0..7 = 0x11..0x18, awready/wready always 1 and bvalid one cycle after wlast:
  - axi_waddr_o=0x1FC0_0020, axi_wlen_o=7.
  - 8 beats 0x11..0x18, wlast on the 8th.
  - empty_o=1 after bvalid.
- Four pushes with axi_awready_i=0 -> full_o=1 after the 4th; a 5th push is ignored. Release awready -> the four bursts drain in push order.
- axi_wready_i toggling 1,0,1,0 during DATA -> each beat holds while wready=0; no beat is skipped or repeated.
- Push line A=0x0000_1000 (data X), then A again (data Y), then query 0x0000_1014 -> query_hit_o=1 and query_line_o=Y. After both drain, the hit drops to 0.
- When full, push_i held high while bvalid pops an entry -> the push is refused that cycle and accepted the next; count returns to DEPTH.
- aresetn=0 during beat 3 of a burst -> all outputs at reset values asynchronously; after release, empty_o=1 and no AXI activity.
